reflet_gpio_ctrl: RTL and testbench

- Memory-mapped 16-bit GPIO peripheral on the reflet system bus.
- Provides 16 general-purpose inputs, 16 general-purpose outputs and per-pin rising-edge interrupt detection.
- Its single interrupt line feeds the external-interrupt controller.
- Read data is OR-combined with the other bus slaves, so it drives zero when not addressed.

---
 rtl/reflet_gpio_pkg.sv | 17 +
 rtl/reflet_gpio_edge_det.sv | 74 +++++++
 rtl/reflet_gpio_ctrl.sv | 113 +++++++++++
 tb/tb_reflet_gpio_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/reflet_gpio_pkg.sv
// Shared constants for the reflet GPIO peripheral: register offsets and field sizes.
package reflet_gpio_pkg;

    localparam int unsigned GPIO_WIDTH = 16;
    localparam int unsigned GPIO_NREGS = 8;
    localparam int unsigned GPIO_OFF_W = 3;

    localparam logic [GPIO_OFF_W-1:0] GPIO_OFF_GPI_L  = 3'd0;
    localparam logic [GPIO_OFF_W-1:0] GPIO_OFF_GPI_H  = 3'd1;
    localparam logic [GPIO_OFF_W-1:0] GPIO_OFF_GPO_L  = 3'd2;
    localparam logic [GPIO_OFF_W-1:0] GPIO_OFF_GPO_H  = 3'd3;
    localparam logic [GPIO_OFF_W-1:0] GPIO_OFF_MASK_L = 3'd4;
    localparam logic [GPIO_OFF_W-1:0] GPIO_OFF_MASK_H = 3'd5;
    localparam logic [GPIO_OFF_W-1:0] GPIO_OFF_FLAG_L = 3'd6;
    localparam logic [GPIO_OFF_W-1:0] GPIO_OFF_FLAG_H = 3'd7;

endpackage

// File: rtl/reflet_gpio_edge_det.sv
// Input sampling, previous-sample register and masked rising-edge flags with write-1-clear.
// REFLET_GPIO_SYNC_EN inserts a 2-flop synchronizer ahead of the sampling flop.
module reflet_gpio_edge_det
    import reflet_gpio_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [GPIO_WIDTH-1:0] gpi,
    input  logic [GPIO_WIDTH-1:0] mask,
    input  logic [GPIO_WIDTH-1:0] clear,
    output logic [GPIO_WIDTH-1:0] gpi_s,
    output logic [GPIO_WIDTH-1:0] flag,
    output logic                  irq
);

    logic [GPIO_WIDTH-1:0] gpi_s_q,    gpi_s_d;
    logic [GPIO_WIDTH-1:0] gpi_prev_q, gpi_prev_d;
    logic [GPIO_WIDTH-1:0] flag_q,     flag_d;
    logic                  irq_q,      irq_d;
    logic [GPIO_WIDTH-1:0] rise_c;

`ifdef REFLET_GPIO_SYNC_EN
    logic [GPIO_WIDTH-1:0] sync1_q, sync1_d;
    logic [GPIO_WIDTH-1:0] sync2_q, sync2_d;

    always_comb begin
        sync1_d = gpi;
        sync2_d = sync1_q;
        gpi_s_d = sync2_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= gpi;
            sync2_q <= gpi;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end
`else
    always_comb begin
        gpi_s_d = gpi;
    end
`endif

    // Set wins over a simultaneous write-1-clear.
    always_comb begin
        rise_c     = gpi_s_q & ~gpi_prev_q & mask;
        gpi_prev_d = gpi_s_q;
        flag_d     = (flag_q & ~clear) | rise_c;
        irq_d      = |flag_d;
    end

    // Sampling stages load the live input on reset so no false edge follows.
    always_ff @(posedge clk) begin
        if (reset) begin
            gpi_s_q    <= gpi;
            gpi_prev_q <= gpi;
            flag_q     <= '0;
            irq_q      <= 1'b0;
        end else begin
            gpi_s_q    <= gpi_s_d;
            gpi_prev_q <= gpi_prev_d;
            flag_q     <= flag_d;
            irq_q      <= irq_d;
        end
    end

    assign gpi_s = gpi_s_q;
    assign flag  = flag_q;
    assign irq   = irq_q;

endmodule

// File: rtl/reflet_gpio_ctrl.sv
// Memory-mapped 16-bit GPIO peripheral: bus decode, chunked register access, edge interrupts.
// Optional input synchronizer selected with REFLET_GPIO_SYNC_EN.
module reflet_gpio_ctrl
    import reflet_gpio_pkg::*;
#(
    parameter int unsigned wordsize       = 8,
    parameter int unsigned base_addr_size = 7,
    parameter int unsigned base_addr      = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [base_addr_size-1:0] addr,
    input  logic                      write_en,
    input  logic [wordsize-1:0]       data_in,
    output logic [wordsize-1:0]       data_out,
    input  logic [GPIO_WIDTH-1:0]     gpi,
    output logic [GPIO_WIDTH-1:0]     gpo,
    output logic                      interrupt
);

    localparam int unsigned AW = base_addr_size;

    // Bit lanes of the 16-bit field covered by the low and high register of a pair.
    localparam logic [GPIO_WIDTH-1:0] LANE_LO = 16'({wordsize{1'b1}});
    localparam logic [GPIO_WIDTH-1:0] LANE_HI = 16'(LANE_LO << wordsize);

    logic [AW-1:0]         off_full_c;
    logic [GPIO_OFF_W-1:0] off_c;
    logic                  sel_c;
    logic                  wr_c;
    logic [GPIO_WIDTH-1:0] lane_c;
    logic [GPIO_WIDTH-1:0] wdata_c;
    logic [GPIO_WIDTH-1:0] clear_c;

    logic [GPIO_WIDTH-1:0] gpo_q,  gpo_d;
    logic [GPIO_WIDTH-1:0] mask_q, mask_d;

    logic [GPIO_WIDTH-1:0] gpi_s;
    logic [GPIO_WIDTH-1:0] flag;
    logic                  irq;

    function automatic logic [wordsize-1:0] rd_chunk(input logic [GPIO_WIDTH-1:0] f,
                                                     input logic hi);
        logic [GPIO_WIDTH-1:0] shifted;
        shifted = hi ? 16'(f >> wordsize) : f;
        return wordsize'(shifted);
    endfunction

    // Unsigned wrap-around subtraction makes addresses below base_addr fall outside.
    always_comb begin
        off_full_c = addr - AW'(base_addr);
        sel_c      = enable && (off_full_c < AW'(GPIO_NREGS));
        off_c      = off_full_c[GPIO_OFF_W-1:0];
        wr_c       = sel_c && write_en;
        lane_c     = off_c[0] ? LANE_HI : LANE_LO;
        wdata_c    = off_c[0] ? 16'(16'(data_in) << wordsize) : 16'(data_in);
        wdata_c    = wdata_c & lane_c;
    end

    always_comb begin
        gpo_d   = gpo_q;
        mask_d  = mask_q;
        clear_c = '0;
        if (wr_c) begin
            unique case (off_c)
                GPIO_OFF_GPO_L,  GPIO_OFF_GPO_H:  gpo_d   = (gpo_q & ~lane_c) | wdata_c;
                GPIO_OFF_MASK_L, GPIO_OFF_MASK_H: mask_d  = (mask_q & ~lane_c) | wdata_c;
                GPIO_OFF_FLAG_L, GPIO_OFF_FLAG_H: clear_c = wdata_c;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gpo_q  <= '0;
            mask_q <= '0;
        end else begin
            gpo_q  <= gpo_d;
            mask_q <= mask_d;
        end
    end

    reflet_gpio_edge_det u_edge_det (
        .clk   (clk),
        .reset (reset),
        .gpi   (gpi),
        .mask  (mask_q),
        .clear (clear_c),
        .gpi_s (gpi_s),
        .flag  (flag),
        .irq   (irq)
    );

    // Read path is combinational so the OR-combined bus sees data in the access cycle.
    always_comb begin
        data_out = '0;
        if (sel_c) begin
            unique case (off_c)
                GPIO_OFF_GPI_L,  GPIO_OFF_GPI_H:  data_out = rd_chunk(gpi_s,  off_c[0]);
                GPIO_OFF_GPO_L,  GPIO_OFF_GPO_H:  data_out = rd_chunk(gpo_q,  off_c[0]);
                GPIO_OFF_MASK_L, GPIO_OFF_MASK_H: data_out = rd_chunk(mask_q, off_c[0]);
                GPIO_OFF_FLAG_L, GPIO_OFF_FLAG_H: data_out = rd_chunk(flag,   off_c[0]);
                default: data_out = '0;
            endcase
        end
    end

    assign gpo       = gpo_q;
    assign interrupt = irq;

endmodule

// File: tb/tb_reflet_gpio_ctrl.sv
// Scoreboard bench for reflet_gpio_ctrl (wordsize 8, base_addr 0): directed plan plus random traffic.
module tb_reflet_gpio_ctrl;

`ifdef REFLET_GPIO_SYNC_EN
    localparam int D = 3;
`else
    localparam int D = 1;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [6:0]  addr;
    logic        write_en;
    logic [7:0]  data_in;
    logic [7:0]  data_out;
    logic [15:0] gpi;
    logic [15:0] gpo;
    logic        interrupt;

    reflet_gpio_ctrl #(.wordsize(8), .base_addr_size(7), .base_addr(0)) dut (
        .clk(clk), .reset(reset), .enable(enable), .addr(addr), .write_en(write_en),
        .data_in(data_in), .data_out(data_out), .gpi(gpi), .gpo(gpo), .interrupt(interrupt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        int          kind;
        logic [15:0] exp;
        string       name;
    } chk_t;

    chk_t q[$];
    int   cyc_n = 0;
    int   checks = 0;
    int   errors = 0;

    // Reference state: input sample history (index 0 newest) plus register images.
    logic [15:0] smp[$];
    logic [15:0] m_gpo, m_mask, m_flag;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    // Monitor: compare every expectation scheduled for this cycle against the live outputs.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc_n) begin
            chk_t c;
            logic [15:0] act;
            c = q.pop_front();
            case (c.kind)
                0:       act = {8'h00, data_out};
                1:       act = gpo;
                default: act = {15'd0, interrupt};
            endcase
            checks++;
            if (c.cyc != cyc_n || act !== c.exp) begin
                errors++;
                $display("FAIL %s kind=%0d cyc=%0d/%0d actual=%h required=%h",
                         c.name, c.kind, c.cyc, cyc_n, act, c.exp);
            end
        end
    end

    function automatic logic [15:0] exp_read();
        logic [15:0] f;
        if (!(enable && addr < 7'd8)) return 16'h0;
        case (addr[2:1])
            2'd0:    f = smp[D-1];
            2'd1:    f = m_gpo;
            2'd2:    f = m_mask;
            default: f = m_flag;
        endcase
        return addr[0] ? {8'h00, f[15:8]} : {8'h00, f[7:0]};
    endfunction

    function automatic void push_checks(string nm);
        chk_t c;
        c.cyc = cyc_n; c.name = nm;
        c.kind = 0; c.exp = exp_read();            q.push_back(c);
        c.kind = 1; c.exp = m_gpo;                 q.push_back(c);
        c.kind = 2; c.exp = {15'd0, (m_flag != 0)}; q.push_back(c);
    endfunction

    // Register effects of the current inputs at the coming rising edge.
    function automatic void model_edge();
        logic [15:0] rise, byte_val;
        if (reset) begin
            m_gpo = 0; m_mask = 0; m_flag = 0;
            smp = {};
            for (int i = 0; i <= D; i++) smp.push_back(gpi);
            return;
        end
        rise = smp[D-1] & ~smp[D] & m_mask;
        byte_val = addr[0] ? {data_in, 8'h00} : {8'h00, data_in};
        if (enable && write_en && addr < 7'd8) begin
            logic [15:0] keep;
            keep = addr[0] ? 16'h00FF : 16'hFF00;
            case (addr[2:1])
                2'd1: m_gpo  = (m_gpo & keep) | byte_val;
                2'd2: m_mask = (m_mask & keep) | byte_val;
                2'd3: m_flag = m_flag & ~byte_val;
                default: ;
            endcase
        end
        m_flag = m_flag | rise;
        smp.push_front(gpi);
        void'(smp.pop_back());
    endfunction

    task automatic cyc(input bit rst, input bit en, input int a, input bit we,
                       input int d, input logic [15:0] g, input string nm, input bit chk = 1);
        reset = rst; enable = en; addr = 7'(a); write_en = we; data_in = 8'(d); gpi = g;
        if (chk) push_checks(nm);
        model_edge();
        @(posedge clk);
        #1;
    endtask

    logic [15:0] g;

    initial begin
        reset = 1'b1; enable = 1'b0; addr = '0; write_en = 1'b0; data_in = '0; gpi = '0;
        #1;
        cyc(1, 0, 0, 0, 0, 16'h0000, "rst0", 0);
        cyc(1, 1, 2, 0, 0, 16'h0000, "rst_rd_gpo");
        cyc(0, 1, 2, 0, 0, 16'h0000, "rd_off2");
        cyc(0, 1, 3, 0, 0, 16'h0000, "rd_off3");
        cyc(0, 1, 6, 0, 0, 16'h0000, "rd_off6");
        cyc(0, 1, 7, 0, 0, 16'h0000, "rd_off7");

        cyc(0, 1, 2, 1, 8'h34, 16'h0000, "wr_off2");
        cyc(0, 1, 3, 1, 8'h12, 16'h0000, "wr_off3");
        cyc(0, 1, 2, 0, 0, 16'h0000, "rb_off2");
        cyc(0, 1, 3, 0, 0, 16'h0000, "rb_off3");
        cyc(0, 0, 2, 1, 8'h55, 16'h0000, "wr_dis2");
        cyc(0, 0, 3, 1, 8'h66, 16'h0000, "wr_dis3");
        cyc(0, 1, 2, 0, 0, 16'h0000, "rb_after_dis");

        cyc(0, 1, 0, 0, 0, 16'hABCD, "gpi_set");
        for (int i = 0; i < D + 1; i++) cyc(0, 1, 0, 0, 0, 16'hABCD, "gpi_wait");
        cyc(0, 1, 0, 0, 0, 16'hABCD, "rd_gpi_l");
        cyc(0, 1, 1, 0, 0, 16'hABCD, "rd_gpi_h");
        cyc(0, 1, 9, 0, 0, 16'hABCD, "rd_out9");
        cyc(0, 1, 100, 1, 8'hFF, 16'hABCD, "wr_out100");
        cyc(0, 1, 0, 1, 8'hFF, 16'hABCD, "wr_gpi_ignored");

        cyc(0, 1, 4, 1, 8'h01, 16'h0000, "mask_l");
        cyc(0, 1, 5, 1, 8'h00, 16'h0000, "mask_h");
        for (int i = 0; i < D + 2; i++) cyc(0, 1, 6, 0, 0, 16'h0000, "settle0");
        cyc(0, 1, 6, 0, 0, 16'h0001, "edge0");
        for (int i = 0; i < D + 2; i++) cyc(0, 1, 6, 0, 0, 16'h0001, "flag0_wait");
        for (int i = 0; i < D + 3; i++) cyc(0, 1, 6, 0, 0, 16'h0003, "edge1_unmasked");
        cyc(0, 1, 6, 1, 8'h01, 16'h0003, "clr0");
        cyc(0, 1, 6, 0, 0, 16'h0003, "after_clr");

        for (int i = 0; i < D + 2; i++) cyc(0, 1, 6, 0, 0, 16'h0000, "drop0");
        cyc(0, 1, 6, 0, 0, 16'h0001, "rise_again");
        for (int i = 0; i < D - 1; i++) cyc(0, 1, 6, 0, 0, 16'h0001, "rise_align");
        cyc(0, 1, 6, 1, 8'h01, 16'h0001, "clr_vs_set");
        cyc(0, 1, 6, 0, 0, 16'h0001, "set_wins");
        cyc(0, 1, 6, 0, 0, 16'h0001, "set_wins2");

        cyc(1, 1, 6, 0, 0, 16'hFFFF, "rst_ffff");
        cyc(0, 1, 4, 1, 8'hFF, 16'hFFFF, "mask_ff_l");
        cyc(0, 1, 5, 1, 8'hFF, 16'hFFFF, "mask_ff_h");
        for (int i = 0; i < D + 2; i++) cyc(0, 1, 6, 0, 0, 16'hFFFF, "no_spurious_l");
        cyc(0, 1, 7, 0, 0, 16'hFFFF, "no_spurious_h");

        cyc(0, 1, 6, 0, 0, 16'h0000, "pre_rst_low");
        for (int i = 0; i < D + 2; i++) cyc(0, 1, 6, 0, 0, 16'h0000, "pre_rst_wait");
        cyc(0, 1, 6, 0, 0, 16'h0001, "pre_rst_edge");
        for (int i = 0; i < D + 2; i++) cyc(0, 1, 6, 0, 0, 16'h0001, "pre_rst_flag");
        cyc(1, 1, 6, 0, 0, 16'h0001, "rst_flag");
        cyc(0, 1, 6, 0, 0, 16'h0001, "post_rst_flag");
        cyc(0, 1, 4, 0, 0, 16'h0001, "post_rst_mask");

        g = 16'h0;
        for (int i = 0; i < 400; i++) begin
            bit rst, en, we;
            if ($urandom_range(0, 3) == 0) g = g ^ 16'($urandom);
            rst = ($urandom_range(0, 59) == 0);
            en  = ($urandom_range(0, 7) != 0);
            we  = ($urandom_range(0, 2) == 0);
            cyc(rst, en, $urandom_range(0, 11), we, $urandom_range(0, 255), g, "rand");
        end

        @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
